// File: rtl/mux_link_pkg.sv
// Definitions shared by both ends of the time-multiplexed pin link:
// frame length in beats, receiver state encoding and beat bit placement.
package mux_link_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } link_state_e;

    function automatic int calc_beats(input int n_signals, input int w, input int n_pins);
        return (n_signals * w) / n_pins;
    endfunction

    // Beat k carries the flattened word's bits [k*n_pins +: n_pins], LSB-first.
    function automatic int beat_lsb(input int beat, input int n_pins);
        return beat * n_pins;
    endfunction

endpackage

// File: rtl/signal_demultiplexer_if.sv
// Pin-link receive bus: multiplexed beat stream in, reassembled frame and status out.
interface signal_demultiplexer_if #(
    parameter int N_signals = 4,
    parameter int W         = 16,
    parameter int N_pins    = 4
);
    logic [N_pins-1:0]        mux_in;
    logic                     mux_valid;
    logic                     mux_sof;
    logic [N_signals*W-1:0]   signals;
    logic                     signals_valid;
    logic                     frame_err;
    logic [7:0]               frame_cnt;

    modport master (
        output mux_in, mux_valid, mux_sof,
        input  signals, signals_valid, frame_err, frame_cnt
    );

    modport slave (
        input  mux_in, mux_valid, mux_sof,
        output signals, signals_valid, frame_err, frame_cnt
    );
endinterface

// File: rtl/beat_assembler.sv
// Slot-indexed frame buffer; the presented word already includes a beat being
// written this cycle so the final beat can be captured on its own edge.
module beat_assembler
    import mux_link_pkg::*;
#(
    parameter int BEATS  = 16,
    parameter int N_pins = 4,
    parameter int SLOT_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [SLOT_W-1:0]         slot,
    input  logic [N_pins-1:0]         beat_data,
    output logic [BEATS*N_pins-1:0]   word
);

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            localparam int LSB = beat_lsb(gi, N_pins);
            logic              hit;
            logic [N_pins-1:0] data_reg;

            assign hit = wr_en && (slot == SLOT_W'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_reg <= '0;
                end else if (hit) begin
                    data_reg <= beat_data;
                end
            end

            assign word[LSB +: N_pins] = hit ? beat_data : data_reg;
        end
    endgenerate

endmodule

// File: rtl/signal_demultiplexer.sv
// Receive side of the pin link: tracks frame position from the sof marker and
// publishes each completed frame with a one-cycle strobe.
module signal_demultiplexer
    import mux_link_pkg::*;
#(
    parameter int N_signals = 4,
    parameter int W         = 16,
    parameter int N_pins    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    signal_demultiplexer_if.slave  bus
);

    localparam int TOTAL  = N_signals * W;
    localparam int BEATS  = calc_beats(N_signals, W, N_pins);
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int SLOT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (TOTAL % N_pins != 0) begin : g_bad_geometry
            $error("signal_demultiplexer: N_signals*W must be divisible by N_pins");
        end
    endgenerate

    link_state_e        state_reg, state_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic               wr_en;
    logic [SLOT_W-1:0]  slot;
    logic               complete;
    logic               resync;
    logic [TOTAL-1:0]   assembled;

    logic [TOTAL-1:0]   signals_reg;
    logic               signals_valid_reg;
    logic               frame_err_reg;
    logic [7:0]         frame_cnt_reg;

    beat_assembler #(
        .BEATS  (BEATS),
        .N_pins (N_pins),
        .SLOT_W (SLOT_W)
    ) u_beat_assembler (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .slot      (slot),
        .beat_data (bus.mux_in),
        .word      (assembled)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        wr_en         = 1'b0;
        slot          = beat_cnt_reg[SLOT_W-1:0];
        complete      = 1'b0;
        resync        = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.mux_valid && bus.mux_sof) begin
                    wr_en = 1'b1;
                    slot  = '0;
                    if (BEATS == 1) begin
                        complete = 1'b1;
                    end else begin
                        beat_cnt_next = CNT_W'(1);
                        state_next    = RECV;
                    end
                end
            end
            RECV: begin
                if (bus.mux_valid) begin
                    wr_en = 1'b1;
                    if (bus.mux_sof) begin
                        // Resync: drop the partial frame and restart from this beat.
                        resync        = 1'b1;
                        slot          = '0;
                        beat_cnt_next = CNT_W'(1);
                    end else if (beat_cnt_reg == CNT_W'(BEATS - 1)) begin
                        complete      = 1'b1;
                        beat_cnt_next = '0;
                        state_next    = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                beat_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            signals_reg       <= '0;
            signals_valid_reg <= 1'b0;
            frame_err_reg     <= 1'b0;
            frame_cnt_reg     <= '0;
        end else begin
            signals_valid_reg <= complete;
            frame_err_reg     <= resync;
            if (complete) begin
                signals_reg   <= assembled;
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.signals       = signals_reg;
    assign bus.signals_valid = signals_valid_reg;
    assign bus.frame_err     = frame_err_reg;
    assign bus.frame_cnt     = frame_cnt_reg;

endmodule

// File: doc/signal_demultiplexer.md
# signal_demultiplexer

Receive-side counterpart of `signal_multiplexer`. Samples the narrow time-multiplexed pin bus, tracks frame position from a start-of-frame marker, and reassembles the flattened `N_signals × W`-bit word. Each complete word is presented with a one-cycle valid strobe. It sits at the far end of the pin link, feeding downstream consumers of the AMDF result signals.

## Interface
- `N_signals`, default 4: number of signals per frame.
- `W`, default 16: bits per signal.
- `N_pins`, default 4: pin-bus width. `N_signals*W` must be divisible by `N_pins`; violation is an elaboration error.
- `clk`, input, 1: single clock; every flop is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Low forces the reset state immediately; release is synchronous to `clk`.
- `mux_in`, input, `N_pins`: one beat of the multiplexed stream.
- `mux_valid`, input, 1: `mux_in` carries a beat this cycle.
- `mux_sof`, input, 1: this beat is beat 0 of a frame. Ignored unless `mux_valid` is high.
- `signals`, output, `N_signals*W`: last completely received frame, flattened with signal 0 in the LSBs.
- `signals_valid`, output, 1: one-cycle pulse when `signals` updates.
- `frame_err`, output, 1: one-cycle pulse when a partial frame is aborted.
- `frame_cnt`, output, 8: count of good frames; wraps 255→0.

## Operation
- `BEATS = N_signals*W/N_pins`. The default is 16.
- Beat k carries flattened bits `[k*N_pins +: N_pins]`, LSB-first. Beat 0 holds the lowest bits.
- Two-state FSM:
  - **IDLE**: waiting for a frame.
  - **RECV**: frame in progress. `beat_cnt` (width `clog2(BEATS+1)`) holds the number of beats stored.
- **IDLE** behaviour:
  - `mux_valid & mux_sof`: store the beat at slot 0, set `beat_cnt=1`, go to RECV.
  - If `BEATS==1`, that beat completes the frame instead and the state stays IDLE.
  - `mux_valid & !mux_sof`: beat is discarded. No error.
- **RECV** behaviour:
  - `mux_valid & !mux_sof`: store at slot `beat_cnt`, then increment `beat_cnt`.
  - `mux_valid & mux_sof`: pulse `frame_err` and discard the partial frame. The sof beat is stored as slot 0, `beat_cnt=1`, and the state stays RECV. This is a resync, not a drop.
  - `!mux_valid`: hold. Gaps of any length are legal mid-frame; there is no timeout.
- **Completion**, on the edge that stores beat `BEATS-1`:
  - The full assembled word, including that beat, is copied to `signals`.
  - `signals_valid` pulses and `frame_cnt` increments.
  - The state returns to IDLE.
- Assembly uses a separate buffer from `signals`. `signals` changes only on completion; partial frames are never visible.
- A non-sof beat arriving the cycle after completion is ignored, because the state is IDLE.
- Reset values: state IDLE, `beat_cnt=0`, assembly buffer 0, `signals=0`, `signals_valid=0`, `frame_err=0`, `frame_cnt=0`.
- Reset asserted mid-frame discards the partial frame without asserting `frame_err`.

## Timing
- All outputs are registered.
- Completion latency: the last beat is sampled at edge t. `signals`, `signals_valid` and `frame_cnt` change at edge t and are observed in the cycle after t.
- `frame_err` is asserted in the cycle after the offending sof beat is sampled.
- A back-to-back sof immediately after a completion starts a new frame with no bubble. Sustained throughput is one frame per `BEATS` valid cycles.
- `signals_valid` and `frame_err` are never high in the same cycle.

## Structure
- Shared package `mux_link_pkg`, shared with `signal_multiplexer`:
  - `BEATS` computation function.
  - State enum `{IDLE, RECV}`.
  - Beat bit-ordering convention.
- A single sub-module is natural: `beat_assembler`.
  - Holds the slot-indexed write buffer.
  - Takes write-enable, slot index and beat data; presents the assembled word.
- The FSM, counters and output registers stay in `signal_demultiplexer`.

## Test plan
- Reset, then 16 consecutive valid beats, sof on the first, carrying nibbles 0x1..0xF,0x0 → `signals_valid` pulses once, one cycle after the last beat. `signals = 0x0FEDCBA987654321`, `frame_cnt = 1`.
- The same frame with `mux_valid` low for 3 cycles after beats 4 and 11 → identical `signals`. The pulse follows the last beat by one cycle.
- Sof at beat 9 of a frame, then 15 further beats all 0xA → `frame_err` pulses one cycle after the resync beat. One `signals_valid` follows, with all nibbles `0xA` except slot 0, which holds the resync beat's data. `frame_cnt` increments once.
- Valid beats without sof while IDLE, followed by a proper frame → leading beats ignored, no `frame_err`, the correct word is received.
- `reset` driven low at beat 7 and released, then a full frame → outputs are zero during reset, no `frame_err`, and the next frame is received correctly with `frame_cnt = 1`.
- 256 back-to-back frames with no gaps between them → 256 `signals_valid` pulses, no bubbles, and `frame_cnt` wraps to 0.
